// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: memory-mapped window giving a core access to a byte-wide
// UART receive/transmit pair through two small FIFOs, plus free-running cycle
// and retired-instruction counters that software can read and clear.
module mmio_uart_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic        mmio_re,
  input  logic        mmio_we,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [31:0] OFF_STATUS = 32'h0000_0000;
  localparam logic [31:0] OFF_RXDATA = 32'h0000_0004;
  localparam logic [31:0] OFF_TXDATA = 32'h0000_0008;
  localparam logic [31:0] OFF_CYCLE  = 32'h0000_0010;
  localparam logic [31:0] OFF_INSTR  = 32'h0000_0014;
  localparam logic [31:0] OFF_CLEAR  = 32'h0000_0018;

  // address decode
  logic [31:0] off;
  logic        rd_en;
  logic        sel_rxdata;
  logic        sel_txdata;
  logic        sel_clear;

  // receive FIFO
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_empty, rx_full, rx_push, rx_pop;

  // transmit FIFO
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_empty, tx_full, tx_push, tx_pop;

  // counters, read data, post-reset enable
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        run_q, run_d;

  // A load and store in the same cycle is treated as the store alone.
  always_comb begin
    off        = mmio_addr - IO_BASE;
    rd_en      = mmio_re & ~mmio_we;
    sel_rxdata = (off == OFF_RXDATA);
    sel_txdata = (off == OFF_TXDATA);
    sel_clear  = (off == OFF_CLEAR);
  end

  // Fullness is judged from the count at the start of the cycle, so a pop
  // never makes room for a push in the same cycle.
  assign rx_empty      = (rx_cnt_q == '0);
  assign rx_full       = (rx_cnt_q == CNT_FULL);
  assign tx_empty      = (tx_cnt_q == '0);
  assign tx_full       = (tx_cnt_q == CNT_FULL);

  // run_q keeps the receiver stalled until the first edge after reset release.
  assign uart_rx_ready = run_q & ~rx_full;
  assign rx_push       = uart_rx_valid & uart_rx_ready;
  assign rx_pop        = rd_en & sel_rxdata & ~rx_empty;

  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
  assign tx_push       = mmio_we & sel_txdata & ~tx_full;
  assign tx_pop        = uart_tx_valid & uart_tx_ready;

  assign mmio_rdata    = rdata_q;

  // Receive FIFO next-state: write at wr_ptr, advance pointers, track count.
  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = uart_rx_data;
      rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    end
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CNT_ONE;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CNT_ONE;
    end
  end

  // Transmit FIFO next-state: stores push the low byte, the UART side pops.
  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = mmio_wdata[7:0];
      tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    end
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  // Counters wrap naturally at 32 bits; a clear store wins over the increment.
  always_comb begin
    run_d = 1'b1;
    if (mmio_we && sel_clear) begin
      cyc_cnt_d  = '0;
      inst_cnt_d = '0;
    end else begin
      cyc_cnt_d  = cyc_cnt_q + 32'd1;
      inst_cnt_d = inst_cnt_q + {31'd0, inst_retire};
    end
  end

  // Load data mux; anything not a mapped readable offset returns zero.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (off)
        OFF_STATUS: rdata_d = {30'd0, ~rx_empty, ~tx_full};
        OFF_RXDATA: rdata_d = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rd_ptr_q]};
        OFF_CYCLE:  rdata_d = cyc_cnt_q;
        OFF_INSTR:  rdata_d = inst_cnt_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // All state, cleared asynchronously; reset discards any FIFO contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rx_mem_q[i] <= '0;
        tx_mem_q[i] <= '0;
      end
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      cyc_cnt_q   <= '0;
      inst_cnt_q  <= '0;
      rdata_q     <= '0;
      run_q       <= 1'b0;
    end else begin
      rx_mem_q    <= rx_mem_d;
      tx_mem_q    <= tx_mem_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      rdata_q     <= rdata_d;
      run_q       <= run_d;
    end
  end

endmodule

// File: doc/mmio_uart_bridge.md
MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per RX and TX FIFO (power of two, >= 2).
REQ-002 SHALL have parameter IO_BASE, default 32'h8000_0000, meaning base of the MMIO window.
REQ-003 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have mmio_addr  input  32  byte address from the core's execute stage.
REQ-006 SHALL have mmio_re  input  1  load to MMIO window this cycle.
REQ-007 SHALL have mmio_we  input  1  store to MMIO window this cycle.
REQ-008 SHALL have mmio_wdata  input  32  store data.
REQ-009 SHALL have mmio_rdata  output  32  registered load data, consumed by writeback.
REQ-010 SHALL have inst_retire  input  1  one pulse per retired instruction.
REQ-011 SHALL have uart_rx_data  input  8, uart_rx_valid  input  1, uart_rx_ready  output  1  receiver handshake.
REQ-012 SHALL have uart_tx_data  output  8, uart_tx_valid  output  1, uart_tx_ready  input  1  transmitter handshake.

Function
REQ-013 SHALL decode offsets: +0x00 status (R), +0x04 RX data (R, pops), +0x08 TX data (W, pushes), +0x10 cycle counter (R), +0x14 instruction counter (R), +0x18 counter clear (W).
REQ-014 SHALL return status = {30'b0, rx_not_empty, tx_not_full}.
REQ-015 SHALL register mmio_rdata: value appears on the edge after mmio_re, reflecting state before that edge's updates (latency 1).
REQ-016 SHALL drive mmio_rdata 0 on the edge after any cycle with mmio_re low or an unmapped address.
REQ-017 SHALL push RX FIFO when uart_rx_valid && uart_rx_ready; uart_rx_ready = RX not full (combinational from count).
REQ-018 SHALL pop RX FIFO on mmio_re at +0x04 when not empty, returning {24'b0, head}; read when empty returns 0, no pop, pointers unchanged.
REQ-019 SHALL push mmio_wdata[7:0] into TX FIFO on mmio_we at +0x08 when TX not full; write when full is dropped silently.
REQ-020 SHALL drive uart_tx_valid = TX not empty, uart_tx_data = TX head; pop on uart_tx_valid && uart_tx_ready.
REQ-021 SHALL allow simultaneous push and pop on either FIFO: fullness judged from count at start of cycle, count unchanged, data order preserved.
REQ-022 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-023 SHALL increment cycle counter every cycle and instruction counter on inst_retire, both 32-bit, wrapping 0xFFFF_FFFF -> 0.
REQ-024 SHALL clear both counters to 0 on mmio_we at +0x18 (any data), clear taking priority over same-cycle increment.
REQ-025 SHALL ignore mmio_we to read-only offsets and mmio_re to write-only offsets (rdata 0).
REQ-026 SHALL treat mmio_re and mmio_we asserted together as write only.

Reset
REQ-027 SHALL, while rst low, hold both FIFOs empty, counters 0, mmio_rdata 0, uart_tx_valid 0, uart_tx_data 0, uart_rx_ready 0.
REQ-028 SHALL, on rst deassertion, drive uart_rx_ready 1 from the first edge; reset mid-transfer discards all FIFO contents.

Verification
REQ-029 SHALL cover: after reset, read +0x00 -> rdata 0x0000_0001 next edge; read +0x04 -> 0, no pop.
REQ-030 SHALL cover: receiver pushes 0x41,0x42 -> status 0x3; two +0x04 reads return 0x41 then 0x42; third returns 0, status 0x1.
REQ-031 SHALL cover: uart_tx_ready held 0, write 9 bytes 0x00..0x08 (depth 8) -> status bit0 0 after 8th, 0x08 dropped; release ready -> 0x00..0x07 emitted in order.
REQ-032 SHALL cover: RX FIFO full, uart_rx_valid high with same-cycle +0x04 pop -> uart_rx_ready 0, no push, count becomes 7; next cycle push accepted.
REQ-033 SHALL cover: run 100 cycles with inst_retire every other cycle, write +0x18 -> counters read 0 then +0x10/+0x14 advance from 0; force cycle counter 0xFFFF_FFFF -> wraps to 0.
REQ-034 SHALL cover: rst asserted low asynchronously with TX FIFO holding 3 bytes -> uart_tx_valid 0 immediately, status 0x1 after release.
